// File: rtl/modulo_gerenciador_buffers_rolhas_param.sv
// ---------------------------------------------------------------------------
// modulo_gerenciador_buffers_rolhas_param
// Two-level cork buffer manager for the filling/capping line. The operator
// loads batches into the secondary buffer at one cork per clock. When the
// primary buffer runs low, corks move from the secondary buffer to the
// primary buffer automatically. The capper's consume pulse drains the
// primary buffer.
//
// Ports
//   i_clk          system clock (divided clock domain)
//   i_clr          async active-low reset
//   i_enable       0 pauses all movement and ignores i_op_load
//   i_op_load      1-cycle load request; i_op_qty is sampled with it
//   i_op_qty       number of corks to load into the secondary buffer
//   i_consume      1-cycle pulse: the capper used one cork
//   o_sec_count    secondary buffer level
//   o_pri_count    primary buffer level
//   o_load_ack     1-cycle pulse: load request accepted
//   o_load_reject  1-cycle pulse: load request refused
//   o_busy         state != IDLE
//   o_no_cork      primary buffer empty
//   o_pri_low      primary buffer below the transfer threshold
//   o_state        00 IDLE, 01 LOAD, 10 XFER
// ---------------------------------------------------------------------------
module modulo_gerenciador_buffers_rolhas_param #(
  parameter  int SEC_MAX = 99,
  parameter  int PRI_MAX = 20,
  parameter  int PRI_MIN = 5,
  parameter  int BATCH   = 15,
  localparam int SEC_W   = $clog2(SEC_MAX + 1),
  localparam int PRI_W   = $clog2(PRI_MAX + 1)
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_enable,
  input  logic             i_op_load,
  input  logic [SEC_W-1:0] i_op_qty,
  input  logic             i_consume,
  output logic [SEC_W-1:0] o_sec_count,
  output logic [PRI_W-1:0] o_pri_count,
  output logic             o_load_ack,
  output logic             o_load_reject,
  output logic             o_busy,
  output logic             o_no_cork,
  output logic             o_pri_low,
  output logic [1:0]       o_state
);

  // The remaining counter holds either a load quantity or a transfer size.
  localparam int REM_W = (SEC_W > PRI_W) ? SEC_W : PRI_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_XFER = 2'b10
  } state_t;

  state_t           r_state;
  logic [SEC_W-1:0] r_sec;
  logic [PRI_W-1:0] r_pri;
  logic [REM_W-1:0] r_rem;
  logic [SEC_W-1:0] r_qty;
  logic             r_pend;
  logic             r_ack;
  logic             r_rej;

  logic [SEC_W:0]   w_sum;
  logic             w_reject;
  logic [31:0]      w_room;
  logic [31:0]      w_xfer_n;
  logic             w_pri_inc;
  logic             w_pri_dec;
  logic [PRI_W-1:0] w_pri_next;

  always_comb begin
    // One extra bit so the capacity check cannot wrap.
    w_sum    = {1'b0, r_sec} + {1'b0, i_op_qty};
    w_reject = (i_op_qty == '0) || r_pend || (w_sum > (SEC_W+1)'(SEC_MAX));

    // Transfer size = min(BATCH, sec_count, free room in primary).
    w_room   = 32'(PRI_MAX) - 32'(r_pri);
    w_xfer_n = 32'(BATCH);
    if (32'(r_sec) < w_xfer_n) w_xfer_n = 32'(r_sec);
    if (w_room < w_xfer_n)     w_xfer_n = w_room;

    // Consume works regardless of enable/state; a transfer increment on the
    // same edge cancels it out.
    w_pri_inc  = i_enable && (r_state == S_XFER);
    w_pri_dec  = i_consume && (r_pri != '0);
    w_pri_next = r_pri;
    if (w_pri_inc && !w_pri_dec)      w_pri_next = r_pri + PRI_W'(1);
    else if (!w_pri_inc && w_pri_dec) w_pri_next = r_pri - PRI_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_state <= S_IDLE;
      r_sec   <= '0;
      r_pri   <= '0;
      r_rem   <= '0;
      r_qty   <= '0;
      r_pend  <= 1'b0;
      r_ack   <= 1'b0;
      r_rej   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_rej <= 1'b0;
      r_pri <= w_pri_next;
      if (i_enable) begin
        if (i_op_load) begin
          if (w_reject) begin
            r_rej <= 1'b1;
          end else begin
            r_ack  <= 1'b1;
            r_pend <= 1'b1;
            r_qty  <= i_op_qty;
          end
        end
        // Accept needs !r_pend and the LOAD entry needs r_pend, so the two
        // r_pend writes never collide on one edge.
        case (r_state)
          S_IDLE: begin
            if ((r_pri < PRI_W'(PRI_MIN)) && (r_sec != '0)) begin
              r_state <= S_XFER;
              r_rem   <= REM_W'(w_xfer_n);
            end else if (r_pend) begin
              r_state <= S_LOAD;
              r_rem   <= REM_W'(r_qty);
              r_pend  <= 1'b0;
            end
          end
          S_LOAD: begin
            r_sec <= r_sec + SEC_W'(1);
            r_rem <= r_rem - REM_W'(1);
            if (r_rem == REM_W'(1)) r_state <= S_IDLE;
          end
          S_XFER: begin
            r_sec <= r_sec - SEC_W'(1);
            r_rem <= r_rem - REM_W'(1);
            if (r_rem == REM_W'(1)) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_sec_count   = r_sec;
  assign o_pri_count   = r_pri;
  assign o_load_ack    = r_ack;
  assign o_load_reject = r_rej;
  assign o_state       = r_state;
  assign o_busy        = (r_state != S_IDLE);
  assign o_no_cork     = (r_pri == '0);
  assign o_pri_low     = (r_pri < PRI_W'(PRI_MIN));

endmodule

// File: tb/tb_modulo_gerenciador_buffers_rolhas_param.sv
// ---------------------------------------------------------------------------
// Directed bench for modulo_gerenciador_buffers_rolhas_param (default
// parameters: SEC_MAX 99, PRI_MAX 20, PRI_MIN 5, BATCH 15). Inputs change
// 1 time unit after a rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_modulo_gerenciador_buffers_rolhas_param;

  logic       clk = 1'b0;
  logic       clr;
  logic       enable;
  logic       op_load;
  logic [6:0] op_qty;
  logic       consume;
  logic [6:0] sec;
  logic [4:0] pri;
  logic       ack;
  logic       rej;
  logic       busy;
  logic       no_cork;
  logic       pri_low;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  modulo_gerenciador_buffers_rolhas_param dut (
    .i_clk         (clk),
    .i_clr         (clr),
    .i_enable      (enable),
    .i_op_load     (op_load),
    .i_op_qty      (op_qty),
    .i_consume     (consume),
    .o_sec_count   (sec),
    .o_pri_count   (pri),
    .o_load_ack    (ack),
    .o_load_reject (rej),
    .o_busy        (busy),
    .o_no_cork     (no_cork),
    .o_pri_low     (pri_low),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle load request; ack/reject is visible right after the edge.
  task automatic load(input logic [6:0] q);
    op_load = 1'b1;
    op_qty  = q;
    tick();
    op_load = 1'b0;
    op_qty  = '0;
  endtask

  // Bounded wait for IDLE; an expired budget shows up as a failed check.
  task automatic wait_idle(input int budget);
    int n = 0;
    while (state != 2'b00 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle", 32'(state), 32'd0);
  endtask

  initial begin
    clr = 1'b0; enable = 1'b0; op_load = 1'b0; op_qty = '0; consume = 1'b0;
    #12;
    // 1. reset values
    chk("rst_sec", 32'(sec), 0);
    chk("rst_pri", 32'(pri), 0);
    chk("rst_no_cork", 32'(no_cork), 1);
    chk("rst_pri_low", 32'(pri_low), 1);
    chk("rst_state", 32'(state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    clr = 1'b1;
    enable = 1'b1;
    tick();

    // 2. load 30, then automatic transfer of 15
    load(7'd30);
    chk("l30_ack", 32'(ack), 1);
    chk("l30_rej", 32'(rej), 0);
    chk("l30_state_idle", 32'(state), 0);
    tick();
    chk("l30_entry_state", 32'(state), 1);
    chk("l30_entry_busy", 32'(busy), 1);
    chk("l30_entry_sec", 32'(sec), 0);
    repeat (29) tick();
    chk("l30_mid_sec", 32'(sec), 29);
    chk("l30_mid_state", 32'(state), 1);
    tick();
    chk("l30_done_sec", 32'(sec), 30);
    chk("l30_done_state", 32'(state), 0);
    tick();
    chk("x15_entry_state", 32'(state), 2);
    chk("x15_entry_sec", 32'(sec), 30);
    chk("x15_entry_pri", 32'(pri), 0);
    repeat (15) tick();
    chk("x15_sec", 32'(sec), 15);
    chk("x15_pri", 32'(pri), 15);
    chk("x15_state", 32'(state), 0);
    chk("x15_pri_low", 32'(pri_low), 0);
    chk("x15_no_cork", 32'(no_cork), 0);

    // 3. capacity boundary
    load(7'd80);
    chk("l80_ack", 32'(ack), 1);
    tick();
    wait_idle(100);
    chk("l80_sec", 32'(sec), 95);
    chk("l80_pri", 32'(pri), 15);
    load(7'd5);
    chk("l5_rej", 32'(rej), 1);
    chk("l5_ack", 32'(ack), 0);
    chk("l5_sec", 32'(sec), 95);
    load(7'd4);
    chk("l4_ack", 32'(ack), 1);
    tick();
    wait_idle(20);
    chk("l4_sec", 32'(sec), 99);
    load(7'd0);
    chk("l0_rej", 32'(rej), 1);
    chk("l0_ack", 32'(ack), 0);

    // 4. drain to threshold, transfer min(15,99,16)=15
    consume = 1'b1;
    repeat (11) tick();
    consume = 1'b0;
    chk("c11_pri", 32'(pri), 4);
    chk("c11_pri_low", 32'(pri_low), 1);
    chk("c11_state", 32'(state), 0);
    tick();
    chk("x_entry_state", 32'(state), 2);
    chk("x_entry_sec", 32'(sec), 99);
    chk("x_entry_pri", 32'(pri), 4);
    // 5a. consume on a transfer edge holds pri
    consume = 1'b1;
    tick();
    consume = 1'b0;
    chk("xc_pri_held", 32'(pri), 4);
    chk("xc_sec", 32'(sec), 98);
    wait_idle(40);
    chk("xc_pri_end", 32'(pri), 18);
    chk("xc_sec_end", 32'(sec), 84);

    // 5b. transfer bounded by sec_count, then drain primary to empty
    clr = 1'b0;
    #2;
    clr = 1'b1;
    tick();
    load(7'd7);
    tick();
    wait_idle(20);
    chk("l7_sec", 32'(sec), 7);
    tick();
    chk("x7_state", 32'(state), 2);
    wait_idle(20);
    chk("x7_pri", 32'(pri), 7);
    chk("x7_sec", 32'(sec), 0);
    consume = 1'b1;
    repeat (7) tick();
    chk("drain_pri", 32'(pri), 0);
    chk("drain_no_cork", 32'(no_cork), 1);
    repeat (3) tick();
    consume = 1'b0;
    chk("underflow_pri", 32'(pri), 0);
    chk("underflow_state", 32'(state), 0);

    // 6. pause mid-load, pending rules, transfer priority, clr mid-transfer
    load(7'd10);
    chk("l10_ack", 32'(ack), 1);
    tick();
    chk("l10_state", 32'(state), 1);
    repeat (3) tick();
    chk("l10_sec3", 32'(sec), 3);
    enable = 1'b0;
    op_load = 1'b1;
    op_qty = 7'd5;
    repeat (3) tick();
    chk("pause_sec", 32'(sec), 3);
    chk("pause_state", 32'(state), 1);
    chk("pause_ack", 32'(ack), 0);
    chk("pause_rej", 32'(rej), 0);
    op_load = 1'b0;
    op_qty = '0;
    enable = 1'b1;
    load(7'd2);
    chk("pend_ack", 32'(ack), 1);
    chk("pend_sec", 32'(sec), 4);
    load(7'd2);
    chk("pend_rej", 32'(rej), 1);
    chk("pend_rej_sec", 32'(sec), 5);
    wait_idle(20);
    chk("l10_sec", 32'(sec), 10);
    tick();
    chk("prio_state", 32'(state), 2);
    repeat (3) tick();
    chk("x10_sec", 32'(sec), 7);
    chk("x10_pri", 32'(pri), 3);
    clr = 1'b0;
    #2;
    chk("clr_sec", 32'(sec), 0);
    chk("clr_pri", 32'(pri), 0);
    chk("clr_state", 32'(state), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_no_cork", 32'(no_cork), 1);
    chk("clr_pri_low", 32'(pri_low), 1);
    clr = 1'b1;
    tick();
    tick();
    chk("clr_pend_gone", 32'(state), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
